// File: rtl/iic_write_master_if.sv
// Request/bus bundle for iic_write_master: frame inputs, ready handshake and SCL.
// SDA stays a plain open-drain inout on the module so it resolves with board pull-ups.
interface iic_write_master_if;
    logic       flag_i;
    logic [6:0] Slv_Addr_i;
    logic [7:0] Reg_Addr_i;
    logic [7:0] Data_i;
    logic       scl;
    logic       ready_o;

    modport master (
        input  flag_i, Slv_Addr_i, Reg_Addr_i, Data_i,
        output scl, ready_o
    );

    modport slave (
        output flag_i, Slv_Addr_i, Reg_Addr_i, Data_i,
        input  scl, ready_o
    );
endinterface

// File: rtl/iic_write_master.sv
// Single-master I2C 3-byte register write engine (START, addr+W, reg, data, STOP).
// Define IIC_ACK_CHECK_EN to abort to STOP on a NACK; otherwise ACK slots are clocked but ignored.
module iic_write_master #(
    parameter int CLK_DIV = 500
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    iic_write_master_if.master   bus,
    inout  wire                  sda
);

    localparam int QTR = CLK_DIV / 4;
    localparam int DW  = (QTR > 1) ? $clog2(QTR) : 1;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ACK1, REG, ACK2, DATA, ACK3, STOP
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] div_cnt;
    logic [1:0]    qtr;
    logic [2:0]    bit_cnt;
    logic [23:0]   frame;
    logic          tick, phase_end, in_byte, in_ack, ack_fail;
    logic          scl_c, sda_low;

    assign tick      = (div_cnt == DW'(QTR - 1));
    assign phase_end = tick && (qtr == 2'd3);
    assign in_byte   = (state inside {ADDR, REG, DATA});
    assign in_ack    = (state inside {ACK1, ACK2, ACK3});

`ifdef IIC_ACK_CHECK_EN
    logic nack;
    assign ack_fail = nack;
`else
    assign ack_fail = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.flag_i)                     state_nxt = START;
            START: if (phase_end)                      state_nxt = ADDR;
            ADDR:  if (phase_end && bit_cnt == 3'd7)   state_nxt = ACK1;
            ACK1:  if (phase_end)                      state_nxt = ack_fail ? STOP : REG;
            REG:   if (phase_end && bit_cnt == 3'd7)   state_nxt = ACK2;
            ACK2:  if (phase_end)                      state_nxt = ack_fail ? STOP : DATA;
            DATA:  if (phase_end && bit_cnt == 3'd7)   state_nxt = ACK3;
            ACK3:  if (phase_end)                      state_nxt = STOP;
            STOP:  if (phase_end)                      state_nxt = IDLE;
            default:                                   state_nxt = IDLE;
        endcase
    end

    // Divider and quarter counter only run while a frame is in flight; the
    // frame shift register presents the current bit at its MSB.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_cnt <= '0;
            qtr     <= '0;
            bit_cnt <= '0;
            frame   <= '0;
`ifdef IIC_ACK_CHECK_EN
            nack    <= 1'b0;
`endif
        end else if (state == IDLE) begin
            div_cnt <= '0;
            qtr     <= '0;
            bit_cnt <= '0;
            if (bus.flag_i)
                frame <= {bus.Slv_Addr_i, 1'b0, bus.Reg_Addr_i, bus.Data_i};
        end else begin
            if (tick) begin
                div_cnt <= '0;
                qtr     <= qtr + 2'd1;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
            if (phase_end && in_byte) begin
                bit_cnt <= bit_cnt + 3'd1;
                frame   <= {frame[22:0], 1'b0};
            end
`ifdef IIC_ACK_CHECK_EN
            if (tick && qtr == 2'd2 && in_ack)
                nack <= sda;
`endif
        end
    end

    always_comb begin
        scl_c   = 1'b1;
        sda_low = 1'b0;
        case (state)
            START: begin
                scl_c   = (qtr != 2'd3);
                sda_low = (qtr != 2'd0);
            end
            ADDR, REG, DATA: begin
                scl_c   = (qtr == 2'd1) || (qtr == 2'd2);
                sda_low = ~frame[23];
            end
            ACK1, ACK2, ACK3: begin
                scl_c   = (qtr == 2'd1) || (qtr == 2'd2);
                sda_low = 1'b0;
            end
            STOP: begin
                scl_c   = (qtr != 2'd0);
                sda_low = (qtr == 2'd0) || (qtr == 2'd1);
            end
            default: begin
                scl_c   = 1'b1;
                sda_low = 1'b0;
            end
        endcase
    end

    assign sda         = sda_low ? 1'b0 : 1'bz;
    assign bus.scl     = scl_c;
    assign bus.ready_o = (state == IDLE);

endmodule

// File: tb/tb_iic_write_master.sv
// Self-checking bench for iic_write_master: an I2C bus monitor/slave decodes the
// waveform and results are compared against frame rules computed from byte counts.
module tb_iic_write_master;

    localparam int D = 8;

    logic clk = 1'b0;
    logic reset_i = 1'b0;
    wire  sda;
    logic ack_drive = 1'b0;
    bit   ack_en = 1'b1;

    int n_cmp = 0;
    int n_fail = 0;

    iic_write_master_if bus();

    pullup (sda);
    assign sda = ack_drive ? 1'b0 : 1'bz;

    iic_write_master #(.CLK_DIV(D)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus),
        .sda     (sda)
    );

    always #5 clk = ~clk;

    // Bus monitor and acknowledging slave
    int         mon_bits = 0;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    logic [7:0] mon_sh = '0;
    logic [7:0] rx_q[$];
    logic       ps = 1'b1, pd = 1'b1, ms, md;

    initial begin
        forever begin
            @(negedge clk);
            ms = bus.scl;
            md = sda;
            if (ps && ms && pd && !md) begin
                start_cnt++;
                mon_bits = 0;
            end else if (ps && ms && !pd && md) begin
                stop_cnt++;
                mon_bits = 0;
            end else if (!ps && ms) begin
                if (mon_bits % 9 < 8) begin
                    mon_sh = {mon_sh[6:0], md};
                    if (mon_bits % 9 == 7) rx_q.push_back(mon_sh);
                end
                mon_bits++;
            end else if (ps && !ms) begin
                ack_drive = ack_en && (mon_bits % 9 == 8);
            end
            ps = ms;
            pd = md;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference rules: bytes sent and ready-low length follow from the ACK outcome
    function automatic int exp_bytes(input bit acked);
`ifdef IIC_ACK_CHECK_EN
        return acked ? 3 : 1;
`else
        return 3;
`endif
    endfunction

    function automatic int exp_len(input bit acked);
        return (1 + 9 * exp_bytes(acked) + 1) * D;
    endfunction

    task automatic run_frame(input logic [6:0] s, input logic [7:0] r, input logic [7:0] d,
                             input bit scramble, output int low, output bit timeout);
        @(negedge clk);
        bus.Slv_Addr_i = s;
        bus.Reg_Addr_i = r;
        bus.Data_i     = d;
        bus.flag_i     = 1'b1;
        low = 0;
        timeout = 1'b1;
        for (int c = 0; c < 40 * D; c++) begin
            @(negedge clk);
            if (c == 1) bus.flag_i = 1'b0;
            if (scramble && c == 3 * D) begin
                bus.Slv_Addr_i = 7'($urandom);
                bus.Reg_Addr_i = 8'($urandom);
                bus.Data_i     = 8'($urandom);
            end
            if (bus.ready_o == 1'b0) low++;
            else if (low > 0) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.flag_i = 1'b0;
        bus.Slv_Addr_i = '0;
        bus.Reg_Addr_i = '0;
        bus.Data_i = '0;
        reset_i = 1'b1;
        #15;
        reset_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
            n_cmp++;
            if (bus.scl !== 1'b1) begin n_fail++; $display("FAIL reset_scl: got %b want 1", bus.scl); end
            n_cmp++;
            if (sda !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b want 1 (released)", sda); end
        end
    endtask

    task automatic test_frames(input int count);
        logic [6:0] s;
        logic [7:0] r, d;
        logic [7:0] want[3];
        int low, base, sb, pb;
        bit to;
        for (int i = 0; i < count; i++) begin
            if (i < 2) begin
                s = 7'h4B; r = 8'h36; d = 8'hC2;
            end else begin
                s = 7'($urandom); r = 8'($urandom); d = 8'($urandom);
            end
            want[0] = {s, 1'b0};
            want[1] = r;
            want[2] = d;
            base = rx_q.size();
            sb = start_cnt;
            pb = stop_cnt;
            run_frame(s, r, d, (i != 0), low, to);
            n_cmp++;
            if (to) begin n_fail++; $display("FAIL frame%0d_timeout: ready_o never returned high", i); end
            n_cmp++;
            if (low != exp_len(1)) begin n_fail++; $display("FAIL frame%0d_latency: got %0d want %0d", i, low, exp_len(1)); end
            n_cmp++;
            if (rx_q.size() - base != 3) begin n_fail++; $display("FAIL frame%0d_nbytes: got %0d want 3", i, rx_q.size() - base); end
            for (int k = 0; k < 3; k++) begin
                if (base + k < rx_q.size()) begin
                    n_cmp++;
                    if (rx_q[base + k] !== want[k]) begin
                        n_fail++;
                        $display("FAIL frame%0d_byte%0d: got %h want %h", i, k, rx_q[base + k], want[k]);
                    end
                end
            end
            n_cmp++;
            if (start_cnt - sb != 1) begin n_fail++; $display("FAIL frame%0d_start: got %0d want 1", i, start_cnt - sb); end
            n_cmp++;
            if (stop_cnt - pb != 1) begin n_fail++; $display("FAIL frame%0d_stop: got %0d want 1", i, stop_cnt - pb); end
            n_cmp++;
            if (bus.scl !== 1'b1 || sda !== 1'b1) begin
                n_fail++; $display("FAIL frame%0d_idle_bus: got scl=%b sda=%b want 1/1", i, bus.scl, sda);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want[6];
        int runs[5];
        int ph, base;
        logic last;
        logic [6:0] sa, sb2;
        logic [7:0] ra, da, rb, db;
        sa = 7'($urandom); ra = 8'($urandom); da = 8'($urandom);
        sb2 = 7'($urandom); rb = 8'($urandom); db = 8'($urandom);
        want = '{{sa, 1'b0}, ra, da, {sb2, 1'b0}, rb, db};
        runs = '{0, 0, 0, 0, 0};
        base = rx_q.size();
        @(negedge clk);
        bus.Slv_Addr_i = sa; bus.Reg_Addr_i = ra; bus.Data_i = da;
        bus.flag_i = 1'b1;
        ph = 0;
        last = 1'b1;
        for (int c = 0; c < 80 * D && ph < 4; c++) begin
            @(negedge clk);
            if (bus.ready_o !== last) begin
                ph++;
                last = bus.ready_o;
                if (ph == 3) bus.flag_i = 1'b0;
            end
            if (ph == 1 && runs[1] == 3 * D) begin
                bus.Slv_Addr_i = sb2; bus.Reg_Addr_i = rb; bus.Data_i = db;
            end
            if (ph < 5) runs[ph]++;
        end
        bus.flag_i = 1'b0;
        n_cmp++;
        if (ph != 4) begin n_fail++; $display("FAIL b2b_timeout: reached phase %0d want 4", ph); end
        n_cmp++;
        if (runs[1] != exp_len(1)) begin n_fail++; $display("FAIL b2b_len1: got %0d want %0d", runs[1], exp_len(1)); end
        n_cmp++;
        if (runs[2] != 1) begin n_fail++; $display("FAIL b2b_gap: got %0d want 1", runs[2]); end
        n_cmp++;
        if (runs[3] != exp_len(1)) begin n_fail++; $display("FAIL b2b_len2: got %0d want %0d", runs[3], exp_len(1)); end
        n_cmp++;
        if (rx_q.size() - base != 6) begin n_fail++; $display("FAIL b2b_nbytes: got %0d want 6", rx_q.size() - base); end
        for (int k = 0; k < 6; k++) begin
            if (base + k < rx_q.size()) begin
                n_cmp++;
                if (rx_q[base + k] !== want[k]) begin
                    n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", k, rx_q[base + k], want[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        @(negedge clk);
        bus.Slv_Addr_i = 7'($urandom); bus.Reg_Addr_i = 8'($urandom); bus.Data_i = 8'($urandom);
        bus.flag_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.flag_i = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 * D; c++) begin
            if (mon_bits == 12) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (!found) begin n_fail++; $display("FAIL rstmid_reach_reg: bit 12 never seen, got %0d want 12", mon_bits); end
        n_cmp++;
        if (bus.ready_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", bus.ready_o); end
        reset_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", bus.ready_o); end
        n_cmp++;
        if (bus.scl !== 1'b1) begin n_fail++; $display("FAIL rstmid_scl: got %b want 1", bus.scl); end
        n_cmp++;
        if (sda !== 1'b1) begin n_fail++; $display("FAIL rstmid_sda: got %b want 1", sda); end
        reset_i = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.ready_o !== 1'b1 || bus.scl !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_stay_idle: got ready=%b scl=%b want 1/1", bus.ready_o, bus.scl);
        end
    endtask

    task automatic test_nack();
        logic [6:0] s;
        int low, base;
        bit to;
        s = 7'($urandom);
        ack_en = 1'b0;
        base = rx_q.size();
        run_frame(s, 8'($urandom), 8'($urandom), 1'b0, low, to);
        ack_en = 1'b1;
        n_cmp++;
        if (to) begin n_fail++; $display("FAIL nack_timeout: ready_o never returned high"); end
        n_cmp++;
        if (low != exp_len(0)) begin n_fail++; $display("FAIL nack_latency: got %0d want %0d", low, exp_len(0)); end
        n_cmp++;
        if (rx_q.size() - base != exp_bytes(0)) begin
            n_fail++; $display("FAIL nack_nbytes: got %0d want %0d", rx_q.size() - base, exp_bytes(0));
        end
        if (rx_q.size() > base) begin
            n_cmp++;
            if (rx_q[base] !== {s, 1'b0}) begin n_fail++; $display("FAIL nack_addr: got %h want %h", rx_q[base], {s, 1'b0}); end
        end
    endtask

    initial begin
        test_reset();
        test_frames(6);
        test_back_to_back();
        test_reset_mid();
        test_frames(3);
        test_nack();
        test_frames(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
